shift_rotate_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 21 ++
 rtl/shift_step.sv | 41 ++++
 rtl/shift_rotate_unit.sv | 99 +++++++++
 tb/tb_shift_rotate_unit.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, datapath sizing and the
// shift/rotate unit state encoding.
package alu_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    OP_ROR = 2'b00,
    OP_ROL = 2'b01,
    OP_SHR = 2'b10,
    OP_SHL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate step: maps (work, op) to the next work value and the
// bit that falls off the end.
module shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] work,
  input  op_e              op,
  output logic [WIDTH-1:0] next_work,
  output logic             bit_out
);

  always_comb begin
    next_work = work;
    bit_out   = 1'b0;
    case (op)
      OP_ROR: begin
        next_work = {work[0], work[WIDTH-1:1]};
        bit_out   = work[0];
      end
      OP_ROL: begin
        next_work = {work[WIDTH-2:0], work[WIDTH-1]};
        bit_out   = work[WIDTH-1];
      end
      OP_SHR: begin
        next_work = {1'b0, work[WIDTH-1:1]};
        bit_out   = work[0];
      end
      OP_SHL: begin
        next_work = {work[WIDTH-2:0], 1'b0};
        bit_out   = work[WIDTH-1];
      end
      default: begin
        next_work = work;
        bit_out   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate stage: one bit per clock, start/busy/done handshake,
// result with carry and zero flags held until the next completion.
module shift_rotate_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int CNT_W = alu_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  // Handshake: start is sampled only in IDLE; busy is high in SHIFT and DONE;
  // done pulses for the single DONE cycle and result/carry/zero are valid from
  // that cycle until the next completion. start during busy is dropped.

  state_e           state;
  op_e              op_q;
  logic [WIDTH-1:0] work;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] next_work;
  logic             bit_out;
  logic [CNT_W-1:0] amount;
  logic             unused_b_hi;

  assign amount      = B[CNT_W-1:0];
  assign unused_b_hi = ^B[WIDTH-1:CNT_W];
  assign busy        = (state != ST_IDLE);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .work      (work),
    .op        (op_q),
    .next_work (next_work),
    .bit_out   (bit_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_q   <= OP_ROR;
      work   <= '0;
      count  <= '0;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q  <= op_e'(op);
            work  <= A;
            count <= amount;
            if (amount == '0) begin
              // Zero amount completes immediately with the operand unchanged.
              state  <= ST_DONE;
              result <= A;
              carry  <= 1'b0;
              zero   <= (A == '0);
              done   <= 1'b1;
            end else begin
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          work  <= next_work;
          count <= count - 1'b1;
          if (count == 1) begin
            state  <= ST_DONE;
            result <= next_work;
            carry  <= bit_out;
            zero   <= (next_work == '0);
            done   <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Directed bench for shift_rotate_unit: hand-computed vectors, timing of
// done/busy, start filtering while busy, and asynchronous reset mid-operation.
module tb_shift_rotate_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry;
  logic        zero;

  int errors = 0;
  int checks = 0;

  shift_rotate_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .result (result),
    .carry  (carry),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accepts one operation, scrambles the inputs, then checks latency and outputs.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                        input logic [15:0] b, input int n,
                        input logic [15:0] exp_r, input logic exp_c);
    int cyc;
    op = o; A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    A = 16'($urandom);
    B = 16'($urandom);
    op = 2'($urandom_range(0, 3));
    chk({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(n));
    chk({tag, "_result"}, 32'(result), 32'(exp_r));
    chk({tag, "_carry"}, 32'(carry), 32'(exp_c));
    chk({tag, "_zero"}, 32'(zero), 32'(exp_r == 16'h0000));
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_done_cleared"}, 32'(done), 32'd0);
    chk({tag, "_busy_cleared"}, 32'(busy), 32'd0);
    chk({tag, "_result_held"}, 32'(result), 32'(exp_r));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; A = '0; B = '0;
    tick();
    tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_carry", 32'(carry), 32'd0);
    chk("reset_zero", 32'(zero), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("ror1", 2'b00, 16'h0001, 16'h0001, 1, 16'h8000, 1'b1);
    run_op("rol4", 2'b01, 16'h8001, 16'hFFF4, 4, 16'h0018, 1'b0);
    run_op("shr5", 2'b10, 16'h00F0, 16'h0005, 5, 16'h0007, 1'b1);
    run_op("shl1", 2'b11, 16'h8000, 16'h0001, 1, 16'h0000, 1'b1);
    run_op("amt0_shl", 2'b11, 16'h1234, 16'h0010, 0, 16'h1234, 1'b0);
    run_op("amt0_ror", 2'b00, 16'h1234, 16'h0000, 0, 16'h1234, 1'b0);

    // 15-step ROR with start held high and A changing every cycle.
    op = 2'b00; A = 16'hA5A5; B = 16'h000F; start = 1'b1;
    tick();
    for (int i = 1; i <= 15; i++) begin
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_no_done", 32'(done), 32'd0);
      A = 16'h1111 * 16'(i);
      tick();
    end
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_result", 32'(result), 32'h4B4B);
    chk("hold_carry", 32'(carry), 32'd0);
    chk("hold_zero", 32'(zero), 32'd0);
    op = 2'b10; A = 16'h0F0F; B = 16'h0002;
    tick();
    chk("hold_idle_after_done", 32'(busy), 32'd0);
    chk("hold_done_pulse_one", 32'(done), 32'd0);
    tick();
    chk("hold_next_accept", 32'(busy), 32'd1);
    start = 1'b0;
    tick();
    tick();
    chk("hold_next_done", 32'(done), 32'd1);
    chk("hold_next_result", 32'(result), 32'h03C3);
    chk("hold_next_carry", 32'(carry), 32'd1);
    tick();

    // Asynchronous reset two steps into an 8-step SHL.
    op = 2'b11; A = 16'h00FF; B = 16'h0008; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("rst_pre_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_result", 32'(result), 32'd0);
    chk("rst_async_carry", 32'(carry), 32'd0);
    chk("rst_async_zero", 32'(zero), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("rst_no_done", 32'(done), 32'd0);
      chk("rst_idle", 32'(busy), 32'd0);
      chk("rst_result_zero", 32'(result), 32'd0);
      tick();
    end
    run_op("post_rst_shl8", 2'b11, 16'h00FF, 16'h0008, 8, 16'hFF00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
